instruction_decoder: RTL and testbench

INSTRUCTION_DECODER -- requirements
Module: instruction_decoder

---
 rtl/instruction_decoder_pkg.sv | 49 ++++
 rtl/instruction_decoder_opcode_decode.sv | 31 +++
 rtl/instruction_decoder.sv | 95 +++++++++
 tb/tb_instruction_decoder.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/instruction_decoder_pkg.sv
// Shared control-unit definitions: control-state encodings, opcode map,
// instruction field positions and the decoded flag vector.
package instruction_decoder_pkg;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'b000,
    ST_DECODE = 3'b001,
    ST_ALU_WB = 3'b010
  } ctrl_state_t;

  typedef enum logic [3:0] {
    OP_AND  = 4'b0000,
    OP_OR   = 4'b0001,
    OP_ADD  = 4'b0010,
    OP_SUB  = 4'b0011,
    OP_XOR  = 4'b0100,
    OP_LD   = 4'b0101,
    OP_ST   = 4'b0110,
    OP_PUSH = 4'b0111,
    OP_POP  = 4'b1000,
    OP_JUMP = 4'b1001,
    OP_BE   = 4'b1010
  } opcode_t;

  localparam int OPCODE_MSB = 15;
  localparam int OPCODE_LSB = 12;
  localparam int RD_MSB     = 11;
  localparam int RD_LSB     = 9;
  localparam int RS1_MSB    = 8;
  localparam int RS1_LSB    = 6;
  localparam int RS2_MSB    = 5;
  localparam int RS2_LSB    = 3;
  localparam int IMM6_MSB   = 5;
  localparam int IMM6_LSB   = 0;
  localparam int ADDR12_MSB = 11;
  localparam int ADDR12_LSB = 0;

  // be_type marks a branch-on-equal; it only reaches the be output when zflag is set.
  typedef struct packed {
    logic alu;
    logic ld;
    logic st;
    logic push;
    logic pop;
    logic jump;
    logic be_type;
  } flags_t;

endpackage

// File: rtl/instruction_decoder_opcode_decode.sv
// Combinational opcode map: 4-bit opcode to one-hot flag vector, ALU select
// and illegal indication.
module opcode_decode
  import instruction_decoder_pkg::*;
(
  input  logic [3:0] opcode,
  output flags_t     flags,
  output logic [2:0] alu_op,
  output logic       illegal
);

  always_comb begin
    flags   = '0;
    alu_op  = 3'b000;
    illegal = 1'b0;
    case (opcode)
      OP_AND, OP_OR, OP_ADD, OP_SUB, OP_XOR: begin
        flags.alu = 1'b1;
        alu_op    = opcode[2:0];
      end
      OP_LD:   flags.ld      = 1'b1;
      OP_ST:   flags.st      = 1'b1;
      OP_PUSH: flags.push    = 1'b1;
      OP_POP:  flags.pop     = 1'b1;
      OP_JUMP: flags.jump    = 1'b1;
      OP_BE:   flags.be_type = 1'b1;
      default: illegal       = 1'b1;
    endcase
  end

endmodule

// File: rtl/instruction_decoder.sv
// Instruction register plus registered decode outputs and the architectural
// zero flag; loads in FETCH, bubbles in FETCH without a valid word.
module instruction_decoder
  import instruction_decoder_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] instr,
  input  logic        instr_valid,
  input  logic        s2,
  input  logic        s1,
  input  logic        s0,
  input  logic        alu_zero,
  output logic        alu,
  output logic        ld,
  output logic        st,
  output logic        push,
  output logic        pop,
  output logic        jump,
  output logic        be,
  output logic [2:0]  alu_op,
  output logic [2:0]  rd,
  output logic [2:0]  rs1,
  output logic [2:0]  rs2,
  output logic [5:0]  imm6,
  output logic [11:0] addr12,
  output logic        illegal,
  output logic        stall,
  output logic        zflag
);

  logic [15:0] ir;
  flags_t      flags_q;
  flags_t      dec_flags;
  logic [2:0]  dec_alu_op;
  logic        dec_illegal;
  logic [2:0]  state;
  logic        in_fetch;
  logic        in_alu_wb;

  assign state     = {s2, s1, s0};
  assign in_fetch  = (state == ST_FETCH);
  assign in_alu_wb = (state == ST_ALU_WB);

  opcode_decode u_opcode_decode (
    .opcode  (instr[OPCODE_MSB:OPCODE_LSB]),
    .flags   (dec_flags),
    .alu_op  (dec_alu_op),
    .illegal (dec_illegal)
  );

  // Decode happens on the incoming word so flags line up with the IR load edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      ir      <= '0;
      flags_q <= '0;
      alu_op  <= 3'b000;
      illegal <= 1'b0;
      zflag   <= 1'b0;
    end else begin
      if (in_alu_wb) begin
        zflag <= alu_zero;
      end
      if (in_fetch) begin
        if (instr_valid) begin
          ir      <= instr;
          flags_q <= dec_flags;
          alu_op  <= dec_alu_op;
          illegal <= dec_illegal;
        end else begin
          flags_q <= '0;
          illegal <= 1'b0;
        end
      end
    end
  end

  assign alu  = flags_q.alu;
  assign ld   = flags_q.ld;
  assign st   = flags_q.st;
  assign push = flags_q.push;
  assign pop  = flags_q.pop;
  assign jump = flags_q.jump;
  // A not-taken branch presents all flags low.
  assign be   = flags_q.be_type & zflag;

  assign rd     = ir[RD_MSB:RD_LSB];
  assign rs1    = ir[RS1_MSB:RS1_LSB];
  assign rs2    = ir[RS2_MSB:RS2_LSB];
  assign imm6   = ir[IMM6_MSB:IMM6_LSB];
  assign addr12 = ir[ADDR12_MSB:ADDR12_LSB];

  assign stall = in_fetch & ~instr_valid;

endmodule

// File: tb/tb_instruction_decoder.sv
// Self-checking bench for instruction_decoder: directed vector table followed
// by randomized traffic against an opcode-rule reference model.
module tb_instruction_decoder;

  localparam int W = 40;

  logic        clk;
  logic        rst;
  logic [15:0] instr;
  logic        instr_valid;
  logic        s2, s1, s0;
  logic        alu_zero;
  logic        alu, ld, st, push, pop, jump, be;
  logic [2:0]  alu_op, rd, rs1, rs2;
  logic [5:0]  imm6;
  logic [11:0] addr12;
  logic        illegal, stall, zflag;

  int checks = 0;
  int errors = 0;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] act;

  typedef struct {
    logic        r;
    logic [2:0]  state;
    logic        v;
    logic [15:0] ins;
    logic        az;
    logic [6:0]  e_flags;
    logic [2:0]  e_aop;
    logic        e_ill;
    logic        e_stall;
    logic        e_z;
    logic [11:0] e_ir12;
  } vec_t;

  vec_t tbl[$];

  // Reference model state: held word, whether its flags are live, ALU select, zero flag.
  logic [15:0] m_ir;
  logic        m_live;
  logic [2:0]  m_aop;
  logic        m_z;

  instruction_decoder dut (
    .clk         (clk),
    .rst         (rst),
    .instr       (instr),
    .instr_valid (instr_valid),
    .s2          (s2),
    .s1          (s1),
    .s0          (s0),
    .alu_zero    (alu_zero),
    .alu         (alu),
    .ld          (ld),
    .st          (st),
    .push        (push),
    .pop         (pop),
    .jump        (jump),
    .be          (be),
    .alu_op      (alu_op),
    .rd          (rd),
    .rs1         (rs1),
    .rs2         (rs2),
    .imm6        (imm6),
    .addr12      (addr12),
    .illegal     (illegal),
    .stall       (stall),
    .zflag       (zflag)
  );

  // Clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign act = {alu, ld, st, push, pop, jump, be, alu_op, illegal, stall, zflag,
                rd, rs1, rs2, imm6, addr12};

  function automatic logic [W-1:0] pack_exp(input logic [6:0] fl, input logic [2:0] aop,
                                            input logic ill, input logic stl, input logic z,
                                            input logic [11:0] f);
    return {fl, aop, ill, stl, z, f[11:9], f[8:6], f[5:3], f[5:0], f};
  endfunction

  function automatic logic [W-1:0] model_expect(input logic stl);
    int op;
    logic [6:0] fl;
    op = int'(m_ir[15:12]);
    fl = '0;
    if (m_live) begin
      fl[6] = (op <= 4);
      fl[5] = (op == 5);
      fl[4] = (op == 6);
      fl[3] = (op == 7);
      fl[2] = (op == 8);
      fl[1] = (op == 9);
      fl[0] = (op == 10) && m_z;
    end
    return pack_exp(fl, m_aop, m_live && (op >= 11), stl, m_z, m_ir[11:0]);
  endfunction

  task automatic model_step(input logic r, input logic [2:0] state, input logic v,
                            input logic [15:0] ins, input logic az);
    if (r) begin
      m_ir = '0; m_live = 1'b0; m_aop = 3'b000; m_z = 1'b0;
    end else begin
      if (state == 3'd2) m_z = az;
      if (state == 3'd0) begin
        if (v) begin
          m_ir   = ins;
          m_live = 1'b1;
          m_aop  = (ins[15:12] <= 4'd4) ? ins[14:12] : 3'b000;
        end else begin
          m_live = 1'b0;
        end
      end
    end
  endtask

  // Driver: apply one cycle of inputs, advance past the edge.
  task automatic drive_cycle(input logic r, input logic [2:0] state, input logic v,
                             input logic [15:0] ins, input logic az);
    rst = r; {s2, s1, s0} = state; instr_valid = v; instr = ins; alu_zero = az;
    model_step(r, state, v, ins, az);
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [W-1:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp_v);
    end
  endtask

  task automatic add(input logic r, input logic [2:0] state, input logic v,
                     input logic [15:0] ins, input logic az, input logic [6:0] fl,
                     input logic [2:0] aop, input logic ill, input logic stl,
                     input logic z, input logic [11:0] f);
    vec_t t;
    t.r = r; t.state = state; t.v = v; t.ins = ins; t.az = az;
    t.e_flags = fl; t.e_aop = aop; t.e_ill = ill; t.e_stall = stl; t.e_z = z; t.e_ir12 = f;
    tbl.push_back(t);
  endtask

  initial begin
    logic [2:0]  rs;
    logic        rr, rv, raz;
    logic [15:0] ri;
    int          sel;

    rst = 1'b1; instr = '0; instr_valid = 1'b0; {s2, s1, s0} = 3'b000; alu_zero = 1'b0;
    m_ir = '0; m_live = 1'b0; m_aop = 3'b000; m_z = 1'b0;

    // flags order: alu ld st push pop jump be
    add(1, 3'd0, 0, 16'h0000, 0, 7'b0000000, 3'd0, 0, 1, 0, 12'h000);
    add(0, 3'd0, 1, 16'h2A50, 0, 7'b1000000, 3'd2, 0, 0, 0, 12'hA50);
    add(0, 3'd1, 0, 16'h0000, 0, 7'b1000000, 3'd2, 0, 0, 0, 12'hA50);
    add(0, 3'd0, 1, 16'hB000, 0, 7'b0000000, 3'd0, 1, 0, 0, 12'h000);
    add(0, 3'd0, 1, 16'h5000, 0, 7'b0100000, 3'd0, 0, 0, 0, 12'h000);
    add(0, 3'd2, 0, 16'h0000, 1, 7'b0100000, 3'd0, 0, 0, 1, 12'h000);
    add(0, 3'd0, 1, 16'hA123, 0, 7'b0000001, 3'd0, 0, 0, 1, 12'h123);
    add(0, 3'd2, 0, 16'h0000, 0, 7'b0000000, 3'd0, 0, 0, 0, 12'h123);
    add(0, 3'd0, 1, 16'hA123, 0, 7'b0000000, 3'd0, 0, 0, 0, 12'h123);
    add(0, 3'd0, 1, 16'h6000, 0, 7'b0010000, 3'd0, 0, 0, 0, 12'h000);
    add(0, 3'd0, 0, 16'hFFFF, 0, 7'b0000000, 3'd0, 0, 1, 0, 12'h000);
    add(0, 3'd0, 1, 16'h9ABC, 0, 7'b0000010, 3'd0, 0, 0, 0, 12'hABC);
    add(1, 3'd0, 1, 16'h1234, 1, 7'b0000000, 3'd0, 0, 0, 0, 12'h000);
    add(0, 3'd3, 1, 16'hFFFF, 1, 7'b0000000, 3'd0, 0, 0, 0, 12'h000);
    add(1, 3'd0, 0, 16'h1234, 0, 7'b0000000, 3'd0, 0, 1, 0, 12'h000);
    add(0, 3'd0, 1, 16'h0000, 0, 7'b1000000, 3'd0, 0, 0, 0, 12'h000);
    add(0, 3'd0, 1, 16'h7FFF, 0, 7'b0001000, 3'd0, 0, 0, 0, 12'hFFF);
    add(0, 3'd0, 1, 16'h8000, 0, 7'b0000100, 3'd0, 0, 0, 0, 12'h000);
    add(0, 3'd0, 1, 16'h4E3F, 0, 7'b1000000, 3'd4, 0, 0, 0, 12'hE3F);
    add(0, 3'd2, 1, 16'h1000, 1, 7'b1000000, 3'd4, 0, 0, 1, 12'hE3F);
    add(1, 3'd2, 0, 16'h0000, 1, 7'b0000000, 3'd0, 0, 0, 0, 12'h000);
    add(0, 3'd0, 1, 16'h3FC0, 0, 7'b1000000, 3'd3, 0, 0, 0, 12'hFC0);
    add(0, 3'd0, 1, 16'hF000, 0, 7'b0000000, 3'd0, 1, 0, 0, 12'h000);
    add(0, 3'd0, 0, 16'h0000, 0, 7'b0000000, 3'd0, 0, 1, 0, 12'h000);

    @(posedge clk);
    #1;
    for (int i = 0; i < tbl.size(); i++) begin
      drive_cycle(tbl[i].r, tbl[i].state, tbl[i].v, tbl[i].ins, tbl[i].az);
      check($sformatf("vec%0d", i),
            pack_exp(tbl[i].e_flags, tbl[i].e_aop, tbl[i].e_ill, tbl[i].e_stall,
                     tbl[i].e_z, tbl[i].e_ir12));
    end

    // Randomized traffic scored against the reference model
    for (int n = 0; n < 400; n++) begin
      sel = int'($urandom_range(0, 9));
      if (sel < 4)      rs = 3'd0;
      else if (sel < 6) rs = 3'd1;
      else if (sel < 8) rs = 3'd2;
      else              rs = 3'($urandom_range(3, 7));
      rr  = ($urandom_range(0, 31) == 0);
      rv  = ($urandom_range(0, 3) != 0);
      raz = 1'($urandom_range(0, 1));
      ri  = 16'($urandom);
      drive_cycle(rr, rs, rv, ri, raz);
      exp_q.push_back(model_expect((rs == 3'd0) && !rv));
      check($sformatf("rand%0d", n), exp_q.pop_front());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
